// File: rtl/data_bus_lsu_pkg.sv
// rtl/data_bus_lsu_pkg.sv - shared FSM states, funct3 access codes and legality check
package data_bus_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10,
    S_ERR    = 2'b11
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants exist only for loads; halfwords and words must be naturally aligned.
  function automatic logic access_ok(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !we;
      F3_H:    ok = !a[0];
      F3_HU:   ok = !we && !a[0];
      F3_W:    ok = (a == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane enables, store replication and load extraction/extension
module lsu_align
  import data_bus_lsu_pkg::*;
(
  input  logic [2:0]  strb,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    byte_en   = 4'b1111;
    wdata_rep = wdata;
    case (strb[1:0])
      2'b00: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        byte_en   = 4'b0011 << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = rdata_raw >> {addr_lo, 3'b000};
    case (strb)
      F3_B:    rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   rdata_ext = {24'h000000, shifted[7:0]};
      F3_H:    rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   rdata_ext = {16'h0000, shifted[15:0]};
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/data_bus_lsu.sv
// rtl/data_bus_lsu.sv - load/store unit bridging the control unit to a ready-handshake data bus
module data_bus_lsu
  import data_bus_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  strb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [3:0]  busByteEn,
  output logic [31:0] busWData,
  input  logic        busReady,
  input  logic [31:0] busRData
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  strb_q, strb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic [3:0]  lane_en;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  lsu_align u_align (
    .strb      (strb_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata_raw (busRData),
    .byte_en   (lane_en),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      strb_q  <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      strb_q  <= strb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    strb_d  = strb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          strb_d  = strb;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = '0;
          state_d = access_ok(we, strb, addr[1:0]) ? S_ACCESS : S_ERR;
        end
      end
      S_ACCESS: begin
        // A ready in the final allowed cycle still wins over the timeout.
        if (busReady) begin
          state_d = S_RESP;
          if (!we_q) rdata_d = lane_rdata;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_RESP) || (state_q == S_ERR);
  assign err       = (state_q == S_ERR);
  assign rdata     = rdata_q;
  assign busReq    = (state_q == S_ACCESS);
  assign busWe     = busReq && we_q;
  assign busAddr   = {addr_q[31:2], 2'b00};
  assign busByteEn = busReq ? lane_en : 4'b0000;
  assign busWData  = lane_wdata;

endmodule

// File: tb/tb_data_bus_lsu.sv
// tb/tb_data_bus_lsu.sv - directed self-checking bench for data_bus_lsu
module tb_data_bus_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [2:0]  strb;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        busReq, busWe;
  logic [31:0] busAddr;
  logic [3:0]  busByteEn;
  logic [31:0] busWData;
  logic        busReady;
  logic [31:0] busRData;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  data_bus_lsu dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .strb      (strb),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .busReq    (busReq),
    .busWe     (busWe),
    .busAddr   (busAddr),
    .busByteEn (busByteEn),
    .busWData  (busWData),
    .busReady  (busReady),
    .busRData  (busRData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  int          lat, n_acc;
  logic        x_err, we0;
  logic [3:0]  be0;
  logic [31:0] wd0, ad0;

  // Issue one request at a negedge and follow it to done; ready_at is the ACCESS cycle
  // (1-based) in which busReady is driven high, 0 means never.
  task automatic do_xact(input logic xwe, input logic [2:0] xstrb, input logic [31:0] xaddr,
                         input logic [31:0] xwdata, input logic [31:0] xrdata, input int ready_at);
    lat = 0; n_acc = 0; x_err = 1'b0; we0 = 1'b0; be0 = 4'h0; wd0 = 32'h0; ad0 = 32'h0;
    req = 1'b1; we = xwe; strb = xstrb; addr = xaddr; wdata = xwdata; busRData = xrdata;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      req = 1'b0;
      lat++;
      busReady = 1'b0;
      if (busReq) begin
        n_acc++;
        if (n_acc == 1) begin
          be0 = busByteEn; wd0 = busWData; we0 = busWe; ad0 = busAddr;
        end
        if (n_acc == ready_at) busReady = 1'b1;
      end
      if (done) begin
        x_err = err;
        break;
      end
    end
    busReady = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; we = 1'b0; strb = 3'b000; addr = 32'h0; wdata = 32'h0;
    busReady = 1'b0; busRData = 32'h0;
    @(negedge clk);
    chk("rst_busy",   32'(busy),      32'd0);
    chk("rst_done",   32'(done),      32'd0);
    chk("rst_err",    32'(err),       32'd0);
    chk("rst_busreq", 32'(busReq),    32'd0);
    chk("rst_buswe",  32'(busWe),     32'd0);
    chk("rst_be",     32'(busByteEn), 32'd0);
    chk("rst_rdata",  rdata,          32'h0);
    reset = 1'b1;
    @(negedge clk);

    do_xact(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 4);
    chk("sw_be",    32'(be0), 32'hF);
    chk("sw_we",    32'(we0), 32'd1);
    chk("sw_addr",  ad0,      32'h104);
    chk("sw_wdata", wd0,      32'hDEADBEEF);
    chk("sw_lat",   32'(lat), 32'd5);
    chk("sw_acc",   32'(n_acc), 32'd4);
    chk("sw_err",   32'(x_err), 32'd0);
    chk("sw_rdata", rdata,    32'h0);

    do_xact(1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 1);
    chk("lb_be",    32'(be0), 32'h8);
    chk("lb_we",    32'(we0), 32'd0);
    chk("lb_addr",  ad0,      32'h100);
    chk("lb_lat",   32'(lat), 32'd2);
    chk("lb_err",   32'(x_err), 32'd0);
    chk("lb_rdata", rdata,    32'hFFFFFF80);

    do_xact(1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 1);
    chk("lbu_rdata", rdata, 32'h00000080);

    do_xact(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 1);
    chk("sh_be",    32'(be0), 32'hC);
    chk("sh_wdata", wd0,      32'hABCDABCD);
    chk("sh_rdata_held", rdata, 32'h00000080);

    do_xact(1'b1, 3'b000, 32'h101, 32'h00000055, 32'h0, 2);
    chk("sb_be",    32'(be0), 32'h2);
    chk("sb_wdata", wd0,      32'h55555555);

    do_xact(1'b0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 1);
    chk("lh_rdata", rdata, 32'hFFFF8001);
    do_xact(1'b0, 3'b101, 32'h100, 32'h0, 32'h8001F00D, 1);
    chk("lhu_be",    32'(be0), 32'h3);
    chk("lhu_rdata", rdata, 32'h0000F00D);
    do_xact(1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 3);
    chk("lw_rdata", rdata, 32'hCAFEF00D);

    do_xact(1'b0, 3'b010, 32'h101, 32'h0, 32'h11111111, 1);
    chk("lw_mis_lat", 32'(lat),   32'd1);
    chk("lw_mis_acc", 32'(n_acc), 32'd0);
    chk("lw_mis_err", 32'(x_err), 32'd1);
    chk("lw_mis_rdata", rdata,    32'hCAFEF00D);

    do_xact(1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 1);
    chk("st011_lat", 32'(lat),   32'd1);
    chk("st011_acc", 32'(n_acc), 32'd0);
    chk("st011_err", 32'(x_err), 32'd1);
    do_xact(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 1);
    chk("sbu_err", 32'(x_err), 32'd1);

    do_xact(1'b0, 3'b010, 32'h200, 32'h0, 32'h12345678, 0);
    chk("to_acc",   32'(n_acc), 32'd16);
    chk("to_lat",   32'(lat),   32'd17);
    chk("to_err",   32'(x_err), 32'd1);
    chk("to_rdata", rdata,      32'hCAFEF00D);

    do_xact(1'b0, 3'b010, 32'h200, 32'h0, 32'h12345678, 16);
    chk("r16_acc",   32'(n_acc), 32'd16);
    chk("r16_lat",   32'(lat),   32'd17);
    chk("r16_err",   32'(x_err), 32'd0);
    chk("r16_rdata", rdata,      32'h12345678);

    req = 1'b1; we = 1'b0; strb = 3'b010; addr = 32'h300; busReady = 1'b0;
    @(negedge clk);
    chk("rst_mid_acc1", 32'(busReq), 32'd1);
    @(negedge clk);
    chk("busy_req_ignored", 32'(busReq), 32'd1);
    req = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_busreq", 32'(busReq), 32'd0);
    chk("rst_mid_busy",   32'(busy),   32'd0);
    chk("rst_mid_rdata",  rdata,       32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_nodone", 32'(done), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_nodone", 32'(done), 32'd0);
    do_xact(1'b0, 3'b010, 32'h10, 32'h0, 32'h11223344, 1);
    chk("post_rst_lat",   32'(lat),   32'd2);
    chk("post_rst_err",   32'(x_err), 32'd0);
    chk("post_rst_rdata", rdata,      32'h11223344);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/data_bus_lsu.md
DATA_BUS_LSU -- requirements
Module: data_bus_lsu

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max cycles ACCESS waits for busReady before error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 req  input  1  start-transaction pulse from the control unit's S_MEM/L_MEM stage; sampled only in IDLE.
REQ-005 we  input  1  1 = store, 0 = load; captured with req.
REQ-006 strb  input  3  funct3 access code (000 B, 001 H, 010 W, 100 BU, 101 HU); captured with req.
REQ-007 addr  input  32  byte address (ALU result); captured with req.
REQ-008 wdata  input  32  store data (rs2); captured with req.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse on completion (success or error).
REQ-011 err  output  1  one-cycle pulse coincident with done on misalignment, illegal strb, or timeout.
REQ-012 rdata  output  32  extended load result; valid and held from done until the next accepted req.
REQ-013 busReq  output  1  bus request; high only in ACCESS.
REQ-014 busWe  output  1  bus write enable; equals captured we while busReq high, else 0.
REQ-015 busAddr  output  32  captured addr with bits [1:0] forced to 0.
REQ-016 busByteEn  output  4  byte-lane enables.
REQ-017 busWData  output  32  lane-replicated store data.
REQ-018 busReady  input  1  slave completion; sampled only in ACCESS.
REQ-019 busRData  input  32  slave read data; valid in the cycle busReady=1.

Function
REQ-020 FSM states: IDLE, ACCESS, RESP, ERR.
REQ-021 IDLE: on req=1 capture we/strb/addr/wdata; legal and aligned -> ACCESS, else -> ERR.
REQ-022 Legal strb: stores 000/001/010; loads 000/001/010/100/101; all other codes illegal.
REQ-023 Aligned: H/HU need addr[0]=0; W needs addr[1:0]=00; B/BU are always aligned.
REQ-024 ACCESS: busReq=1, bus outputs stable; busReady=1 -> RESP and register extended read result into rdata (loads only).
REQ-025 ACCESS timeout: cycle counter clears on entry; if busReady is still 0 after TIMEOUT_CYCLES cycles -> ERR.
REQ-026 busReady arriving in the same cycle the counter expires counts as success (RESP).
REQ-027 RESP: done=1, err=0 for one cycle, then -> IDLE.
REQ-028 ERR: done=1, err=1 for one cycle, then -> IDLE; no bus request issued, rdata unchanged.
REQ-029 req while busy is ignored, not queued.
REQ-030 Minimum latency, req to done: 2 cycles with busReady=1 in the first ACCESS cycle; error path 1 cycle.
REQ-031 busByteEn: B = 0001<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111; 0000 outside ACCESS.
REQ-032 busWData: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
REQ-033 Load extraction: lane = busRData >> (8*addr[1:0]); B/H sign-extend and BU/HU zero-extend to 32 bits; W passes through.
REQ-034 Stores leave rdata unchanged.

Reset
REQ-035 While reset=0: state=IDLE, counter=0, captured registers=0, rdata=0.
REQ-036 While reset=0: busy, done, err, busReq, busWe = 0; busByteEn=0000.
REQ-037 Reset asserted mid-ACCESS drops busReq asynchronously; the aborted transaction produces no done.

Structure
REQ-038 State enum, funct3 access-code constants and the legality/alignment function live in the shared defines package.
REQ-039 Combinational lane logic (byte enables, write replication, read extraction/extension) sits in sub-module lsu_align; data_bus_lsu holds the FSM, counter and registers.

Verification
REQ-040 SW addr=0x104, wdata=0xDEADBEEF, busReady after 3 cycles -> busByteEn=1111, busWe=1, done at cycle 5, err=0.
REQ-041 LB addr=0x103, busRData=0x80xxxxxx -> busByteEn=1000, rdata=0xFFFFFF80; LBU on the same data -> rdata=0x00000080.
REQ-042 SH addr=0x102, wdata=0x1234ABCD -> busByteEn=1100, busWData=0xABCDABCD.
REQ-043 LW addr=0x101 -> no busReq, done=err=1 the next cycle; strb=011 store -> same response.
REQ-044 LW with busReady held 0 -> err after 16 ACCESS cycles; busReady on cycle 16 -> success.
REQ-045 reset=0 in the second ACCESS cycle -> busReq=0 immediately, no done; after reset=1 a new req completes normally.
